// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - four-digit multiplexed 7-segment driver with guard band, blink and leading-zero blanking
module seg7_scan_mux #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int GUARD        = 1_000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    input  logic        lzb,
    output logic [3:0]  an,
    output logic [7:0]  rish,
    output logic        frame_tick
);
    localparam int DW = $clog2(REFRESH_DIV);

    logic [DW-1:0] div_cnt;
    logic [1:0]    idx;
    logic [7:0]    bcnt;
    logic          blink_phase;
    logic          pend;

    logic [15:0]   sh_digits;
    logic [3:0]    sh_blank;
    logic [3:0]    sh_blink;
    logic [3:0]    sh_dp;
    logic          sh_lzb;
    logic          sh_phase;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    cur;
    logic [3:0]    lz;
    logic          visible;
    logic [6:0]    seg;
    logic [3:0]    an_next;
    logic [7:0]    rish_next;

    assign slot_end = (div_cnt == DW'(REFRESH_DIV - 1));
    // pend forces the first edge out of reset to open a new frame at slot 0
    assign boundary = pend | (slot_end && idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            idx         <= 2'd3;
            bcnt        <= '0;
            blink_phase <= 1'b1;
            pend        <= 1'b1;
            sh_digits   <= '0;
            sh_blank    <= '0;
            sh_blink    <= '0;
            sh_dp       <= '0;
            sh_lzb      <= 1'b0;
            sh_phase    <= 1'b0;
            an          <= 4'hF;
            rish        <= 8'hFF;
            frame_tick  <= 1'b0;
        end else begin
            pend       <= 1'b0;
            frame_tick <= boundary;
            an         <= an_next;
            rish       <= rish_next;
            if (boundary) begin
                div_cnt   <= '0;
                idx       <= 2'd0;
                sh_digits <= digits;
                sh_blank  <= blank_mask;
                sh_blink  <= blink_mask;
                sh_dp     <= dp_mask;
                sh_lzb    <= lzb;
                // the frame being opened uses the phase from before this boundary's toggle
                sh_phase  <= blink_phase;
                if (bcnt == 8'(BLINK_FRAMES - 1)) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + 8'd1;
                end
            end else if (slot_end) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    always_comb begin
        cur   = sh_digits[{idx, 2'b00} +: 4];
        lz    = '0;
        lz[3] = sh_lzb && (sh_digits[15:12] == 4'h0);
        lz[2] = lz[3] && (sh_digits[11:8] == 4'h0);
        lz[1] = lz[2] && (sh_digits[7:4] == 4'h0);
        visible = !sh_blank[idx] && !(sh_blink[idx] && !sh_phase) && !lz[idx];
        case (cur)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        an_next   = 4'hF;
        rish_next = 8'hFF;
        if (div_cnt >= DW'(GUARD) && visible) begin
            an_next   = ~(4'b0001 << idx);
            rish_next = {~sh_dp[idx], seg};
        end
    end
endmodule
